pipeline_job_sequencer: RTL and testbench
=========================================

Name: pipeline_job_sequencer

Overview:
- Sequences whole jobs (one top plus N bots) into the full-pipeline front end.
- Accepts a job descriptor, issues the top-load beat, then streams N bots from an upstream bot stream.
- Limits the number of results in flight and waits for every result before accepting the next job.
- Sits between the host/DMA front end and the pipeline manager; replaces ad-hoc startNewTop/ivalid driving.

Parameters:
- BOT_COUNT_WIDTH, 32, width of per-job bot count and result counters.
- MAX_IN_FLIGHT, 32, maximum bots issued but not yet returned as results (1..2^IFW-1).
- IFW, 6, in-flight counter width; must satisfy MAX_IN_FLIGHT < 2^IFW.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous reset, active-high.
- jobValid  in  1  job descriptor valid.
- jobReady  out  1  sequencer can accept a job.
- jobTop  in  128  top function for the job.
- jobBotCount  in  BOT_COUNT_WIDTH  number of bots in the job (0 allowed).
- botInValid  in  1  upstream bot valid.
- botInReady  out  1  sequencer consumes the bot this cycle.
- botIn  in  128  bot function.
- pipeStartNewTop  out  1  beat on pipeData is a top load.
- pipeValid  out  1  beat valid toward the pipeline manager.
- pipeReady  in  1  pipeline manager accepts the beat (oready).
- pipeData  out  128  top or bot payload.
- resultValid  in  1  one pipeline result returned.
- jobDone  out  1  one-cycle pulse when the last result of a job has returned.
- jobResultCount  out  BOT_COUNT_WIDTH  results counted for the finished job; valid with jobDone.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: all outputs 0, except jobReady=1 once in IDLE on the cycle after rst deasserts. Counters are cleared and state goes to IDLE. Reset mid-job abandons the job silently; results arriving later are ignored until the next job.
- States: IDLE, LOAD_TOP, STREAM, DRAIN, DONE.
- IDLE:
  - jobReady=1.
  - jobValid&jobReady latches top and count into registers, clears sent/received/inFlight, and goes to LOAD_TOP.
- LOAD_TOP:
  - pipeValid=1, pipeStartNewTop=1, pipeData=latched top.
  - On pipeReady: if count==0 go to DONE, else go to STREAM.
- STREAM:
  - pipeValid = botInValid && inFlight<MAX_IN_FLIGHT.
  - pipeData=botIn, pipeStartNewTop=0.
  - botInReady = pipeReady && inFlight<MAX_IN_FLIGHT; the bot is combinationally passed through, zero added latency.
  - A transfer (pipeValid&pipeReady) increments sent and inFlight.
  - When sent reaches count, go to DRAIN on the same transfer edge.
- DRAIN:
  - pipeValid=0, botInReady=0.
  - When received reaches count, go to DONE.
- DONE:
  - jobDone=1 for exactly one cycle, jobResultCount=received.
  - Next state is IDLE.
- Results:
  - resultValid in STREAM/DRAIN increments received and decrements inFlight.
  - In IDLE/LOAD_TOP/DONE, resultValid is ignored.
  - Simultaneous transfer and result in the same cycle leaves inFlight unchanged; received and sent both increment.
- inFlight underflow, i.e. resultValid with inFlight==0 in STREAM/DRAIN, is ignored and flagged by an assertion.
- Counters are not saturating; count is bounded by BOT_COUNT_WIDTH, so no wrap occurs within a job.
- Top-load beat latency: pipeValid rises the cycle after job acceptance.
- Minimum job turnaround: 1 cycle from the last result to jobDone, 1 cycle to jobReady.

Optional Feature:
- JOB_CYCLE_STATS_EN:
  - Defined: adds output jobCycles (32-bit). It counts cycles from the LOAD_TOP entry to DONE inclusive, saturating at all-ones, and is valid with jobDone. It also adds stallCycles (32-bit), which counts STREAM cycles with botInValid=1 but no transfer, with the same saturation rule.
  - Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Job top=0xA5..A5, count=4; bots always valid; pipeReady=1; each result returns 3 cycles after its bot.
  - Required: one top beat with pipeStartNewTop=1, then 4 bot beats in consecutive cycles.
  - Required: jobDone pulses once with jobResultCount=4, then jobReady=1 the next cycle.
- Job count=0:
  - Required: top beat only, then jobDone with jobResultCount=0; botInReady never asserts.
- MAX_IN_FLIGHT=2, count=5, no results until 10 cycles later:
  - Required: only 2 bots are issued, then botInReady=0.
  - Required: each result releases exactly one further bot.
- pipeReady toggled 1/0 every cycle during STREAM with count=6:
  - Required: exactly 6 bot transfers, none duplicated or lost; pipeData is stable while pipeValid&!pipeReady.
- Same-cycle transfer and resultValid at inFlight=MAX_IN_FLIGHT-1:
  - Required: inFlight unchanged and sent/received both +1.
- rst asserted in DRAIN with 2 results outstanding:
  - Required: the next cycle all outputs are 0 and state is IDLE.
  - Required: the late resultValid pulses are ignored, and a new job with count=1 completes with jobResultCount=1.

Source files
------------

// File: rtl/pipeline_job_sequencer.sv
// pipeline_job_sequencer
// Feeds whole jobs (one top-load beat followed by N bot beats) into the
// full-pipeline front end. Bots are passed straight through from the upstream
// stream while the number of outstanding results stays below MAX_IN_FLIGHT.
// The block then waits for every result of the job before it pulses jobDone
// and takes the next job.
// Optional build macro: JOB_CYCLE_STATS_EN adds the jobCycles/stallCycles
// per-job statistics outputs.
module pipeline_job_sequencer #(
    parameter int BOT_COUNT_WIDTH = 32,
    parameter int MAX_IN_FLIGHT   = 32,
    parameter int IFW             = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       jobValid,
    output logic                       jobReady,
    input  logic [127:0]               jobTop,
    input  logic [BOT_COUNT_WIDTH-1:0] jobBotCount,
    input  logic                       botInValid,
    output logic                       botInReady,
    input  logic [127:0]               botIn,
    output logic                       pipeStartNewTop,
    output logic                       pipeValid,
    input  logic                       pipeReady,
    output logic [127:0]               pipeData,
    input  logic                       resultValid,
    output logic                       jobDone,
    output logic [BOT_COUNT_WIDTH-1:0] jobResultCount,
    output logic                       busy
`ifdef JOB_CYCLE_STATS_EN
    ,
    output logic [31:0]                jobCycles,
    output logic [31:0]                stallCycles
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_TOP,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    localparam logic [IFW-1:0]             MAX_IF  = IFW'(MAX_IN_FLIGHT);
    localparam logic [BOT_COUNT_WIDTH-1:0] BC_ONE  = BOT_COUNT_WIDTH'(1);
    localparam logic [IFW-1:0]             IF_ONE  = IFW'(1);

    state_t                       state_q, state_d;
    logic [127:0]                 top_q, top_d;
    logic [BOT_COUNT_WIDTH-1:0]   count_q, count_d;
    logic [BOT_COUNT_WIDTH-1:0]   sent_q, sent_d;
    logic [BOT_COUNT_WIDTH-1:0]   recv_q, recv_d;
    logic [IFW-1:0]               in_flight_q, in_flight_d;

    logic                         has_room;
    logic                         xfer;
    logic                         res_ok;
    logic                         accept;

    // Next-state, counter updates and all handshake outputs.
    always_comb begin
        state_d         = state_q;
        top_d           = top_q;
        count_d         = count_q;
        sent_d          = sent_q;
        recv_d          = recv_q;
        in_flight_d     = in_flight_q;
        jobReady        = 1'b0;
        botInReady      = 1'b0;
        pipeValid       = 1'b0;
        pipeStartNewTop = 1'b0;
        pipeData        = '0;
        jobDone         = 1'b0;
        jobResultCount  = '0;
        xfer            = 1'b0;
        res_ok          = 1'b0;
        accept          = 1'b0;
        has_room        = (in_flight_q < MAX_IF);

        case (state_q)
            IDLE: begin
                // Held low while rst is high so reset shows all-zero outputs.
                jobReady = !rst;
                accept   = jobValid && !rst;
                if (accept) begin
                    top_d       = jobTop;
                    count_d     = jobBotCount;
                    sent_d      = '0;
                    recv_d      = '0;
                    in_flight_d = '0;
                    state_d     = LOAD_TOP;
                end
            end
            LOAD_TOP: begin
                pipeValid       = 1'b1;
                pipeStartNewTop = 1'b1;
                pipeData        = top_q;
                if (pipeReady) begin
                    state_d = (count_q == '0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                // Zero-latency pass-through of the upstream bot.
                pipeValid  = botInValid && has_room;
                pipeData   = botIn;
                botInReady = pipeReady && has_room;
                xfer       = botInValid && has_room && pipeReady;
                res_ok     = resultValid && (in_flight_q != '0);
                if (xfer && ((sent_q + BC_ONE) == count_q)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                res_ok = resultValid && (in_flight_q != '0);
                if (res_ok && ((recv_q + BC_ONE) == count_q)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                jobDone        = 1'b1;
                jobResultCount = recv_q;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (xfer) begin
            sent_d = sent_q + BC_ONE;
        end
        if (res_ok) begin
            recv_d = recv_q + BC_ONE;
        end
        // A transfer and a result in the same cycle cancel out.
        case ({xfer, res_ok})
            2'b10:   in_flight_d = in_flight_q + IF_ONE;
            2'b01:   in_flight_d = in_flight_q - IF_ONE;
            default: ;
        endcase
    end

    assign busy = (state_q != IDLE);

    // State and job registers; reset abandons any job in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            top_q       <= '0;
            count_q     <= '0;
            sent_q      <= '0;
            recv_q      <= '0;
            in_flight_q <= '0;
        end else begin
            state_q     <= state_d;
            top_q       <= top_d;
            count_q     <= count_d;
            sent_q      <= sent_d;
            recv_q      <= recv_d;
            in_flight_q <= in_flight_d;
        end
    end

`ifdef JOB_CYCLE_STATS_EN
    logic [31:0] cycles_q, cycles_d;
    logic [31:0] stall_q, stall_d;
    logic [31:0] cycles_inc;

    // Saturating per-job cycle and stall counters.
    always_comb begin
        cycles_d   = cycles_q;
        stall_d    = stall_q;
        cycles_inc = (cycles_q == '1) ? cycles_q : cycles_q + 32'd1;
        if (accept) begin
            cycles_d = '0;
            stall_d  = '0;
        end else if (state_q == LOAD_TOP || state_q == STREAM || state_q == DRAIN) begin
            cycles_d = cycles_inc;
            if (state_q == STREAM && botInValid && !xfer && stall_q != '1) begin
                stall_d = stall_q + 32'd1;
            end
        end
        // The DONE cycle itself is included in the reported count.
        jobCycles   = (state_q == DONE) ? cycles_inc : '0;
        stallCycles = (state_q == DONE) ? stall_q : '0;
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycles_q <= '0;
            stall_q  <= '0;
        end else begin
            cycles_q <= cycles_d;
            stall_q  <= stall_d;
        end
    end
`endif

    // A result with nothing outstanding is dropped; flag it in simulation.
    underflow_chk: assert property (@(posedge clk) disable iff (rst)
        !(resultValid && (state_q == STREAM || state_q == DRAIN) && in_flight_q == '0));

endmodule

// File: tb/tb_pipeline_job_sequencer.sv
// Testbench for pipeline_job_sequencer. Two instances share the input
// stimulus: dut_a with MAX_IN_FLIGHT=4 and dut_b with MAX_IN_FLIGHT=2; only the
// selected one ever receives jobValid, so the other stays idle.
module tb_pipeline_job_sequencer;
    localparam int BCW   = 32;
    localparam int MAX_A = 4;
    localparam int MAX_B = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst = 1'b1;
    logic             jobValid = 1'b0;
    logic             pipeReady = 1'b0;
    logic             botInValid = 1'b0;
    logic             resultValid = 1'b0;
    logic [127:0]     jobTop = '0;
    logic [127:0]     botIn = '0;
    logic [BCW-1:0]   jobBotCount = '0;
    int               sel = 0;

    logic jv_a, jv_b;
    assign jv_a = jobValid && (sel == 0);
    assign jv_b = jobValid && (sel == 1);

    logic a_jr, a_bir, a_snt, a_pv, a_done, a_busy;
    logic b_jr, b_bir, b_snt, b_pv, b_done, b_busy;
    logic [127:0] a_pd, b_pd;
    logic [BCW-1:0] a_jrc, b_jrc;

    pipeline_job_sequencer #(.BOT_COUNT_WIDTH(BCW), .MAX_IN_FLIGHT(MAX_A), .IFW(6)) dut_a (
        .clk(clk), .rst(rst), .jobValid(jv_a), .jobReady(a_jr), .jobTop(jobTop),
        .jobBotCount(jobBotCount), .botInValid(botInValid), .botInReady(a_bir), .botIn(botIn),
        .pipeStartNewTop(a_snt), .pipeValid(a_pv), .pipeReady(pipeReady), .pipeData(a_pd),
        .resultValid(resultValid), .jobDone(a_done), .jobResultCount(a_jrc), .busy(a_busy)
    );

    pipeline_job_sequencer #(.BOT_COUNT_WIDTH(BCW), .MAX_IN_FLIGHT(MAX_B), .IFW(6)) dut_b (
        .clk(clk), .rst(rst), .jobValid(jv_b), .jobReady(b_jr), .jobTop(jobTop),
        .jobBotCount(jobBotCount), .botInValid(botInValid), .botInReady(b_bir), .botIn(botIn),
        .pipeStartNewTop(b_snt), .pipeValid(b_pv), .pipeReady(pipeReady), .pipeData(b_pd),
        .resultValid(resultValid), .jobDone(b_done), .jobResultCount(b_jrc), .busy(b_busy)
    );

    logic jobReady, botInReady, pipeStartNewTop, pipeValid, jobDone, busy;
    logic [127:0] pipeData;
    logic [BCW-1:0] jobResultCount;
    assign jobReady        = (sel == 0) ? a_jr   : b_jr;
    assign botInReady      = (sel == 0) ? a_bir  : b_bir;
    assign pipeStartNewTop = (sel == 0) ? a_snt  : b_snt;
    assign pipeValid       = (sel == 0) ? a_pv   : b_pv;
    assign jobDone         = (sel == 0) ? a_done : b_done;
    assign busy            = (sel == 0) ? a_busy : b_busy;
    assign pipeData        = (sel == 0) ? a_pd   : b_pd;
    assign jobResultCount  = (sel == 0) ? a_jrc  : b_jrc;

    int checks = 0;
    int errors = 0;

    // Per-job observations left behind by run_job for scenario-specific checks.
    int st_xfer_n, st_first, st_last, st_max_out, st_bir_high, st_done_pulses, st_stall_holds;

    // Runs one complete job against a transaction-level model: the expected
    // beat sequence is the top followed by the bots in order, outstanding
    // results never exceed the in-flight limit, jobDone follows the last
    // result by one cycle and jobReady returns the cycle after that.
    task automatic run_job(input int dut, input logic [127:0] top, input int count,
                           input int ready_mode, input int bv_pct,
                           input int dly_min, input int dly_max);
        int maxf, sent, recv, phase, due_idx, cyc_used;
        bit done;
        int pend[$];
        logic [127:0] bots[$];
        logic room, e_pv, e_snt, e_bir, e_done, e_busy, e_jr, prev_hold;
        logic [127:0] e_pd, prev_pd;
        sel  = dut;
        maxf = (dut == 0) ? MAX_A : MAX_B;
        for (int i = 0; i < count; i++) bots.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
        st_xfer_n = 0; st_first = -1; st_last = -1; st_max_out = 0;
        st_bir_high = 0; st_done_pulses = 0; st_stall_holds = 0;

        @(negedge clk);
        pipeReady = 1'b0; botInValid = 1'b0; resultValid = 1'b0;
        #1;
        checks++;
        if (jobReady !== 1'b1) begin
            errors++;
            $display("FAIL job_ready_idle dut=%0d got %b want 1", dut, jobReady);
        end
        jobValid = 1'b1; jobTop = top; jobBotCount = BCW'(count);
        @(negedge clk);
        jobValid = 1'b0;
        jobTop = {$urandom(), $urandom(), $urandom(), $urandom()};
        jobBotCount = $urandom();

        sent = 0; recv = 0; phase = 0; prev_hold = 1'b0; prev_pd = '0; done = 1'b0; cyc_used = 0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            if (cyc > 0) @(negedge clk);
            cyc_used = cyc;
            case (ready_mode)
                0:       pipeReady = 1'b1;
                1:       pipeReady = ((cyc % 2) == 0);
                default: pipeReady = ($urandom_range(0, 1) == 1);
            endcase
            botInValid = ($urandom_range(1, 100) <= bv_pct);
            botIn = (sent < count) ? bots[sent] : {$urandom(), $urandom(), $urandom(), $urandom()};
            due_idx = -1;
            foreach (pend[i]) if (due_idx < 0 && pend[i] <= cyc) due_idx = i;
            resultValid = (due_idx >= 0);
            #1;
            room   = (sent - recv) < maxf;
            e_pv   = (phase == 0) || (phase == 1 && sent < count && botInValid && room);
            e_snt  = (phase == 0);
            e_bir  = (phase == 1 && sent < count && pipeReady && room);
            e_done = (phase == 2);
            e_busy = (phase != 3);
            e_jr   = (phase == 3);
            e_pd   = (phase == 0) ? top : ((sent < count) ? bots[sent] : '0);

            checks++;
            if (pipeValid !== e_pv) begin
                errors++;
                $display("FAIL pipeValid dut=%0d cyc=%0d got %b want %b", dut, cyc, pipeValid, e_pv);
            end
            checks++;
            if (pipeStartNewTop !== e_snt) begin
                errors++;
                $display("FAIL pipeStartNewTop dut=%0d cyc=%0d got %b want %b", dut, cyc, pipeStartNewTop, e_snt);
            end
            checks++;
            if (botInReady !== e_bir) begin
                errors++;
                $display("FAIL botInReady dut=%0d cyc=%0d got %b want %b", dut, cyc, botInReady, e_bir);
            end
            checks++;
            if (jobDone !== e_done) begin
                errors++;
                $display("FAIL jobDone dut=%0d cyc=%0d got %b want %b", dut, cyc, jobDone, e_done);
            end
            checks++;
            if (busy !== e_busy) begin
                errors++;
                $display("FAIL busy dut=%0d cyc=%0d got %b want %b", dut, cyc, busy, e_busy);
            end
            checks++;
            if (jobReady !== e_jr) begin
                errors++;
                $display("FAIL jobReady dut=%0d cyc=%0d got %b want %b", dut, cyc, jobReady, e_jr);
            end
            if (e_pv) begin
                checks++;
                if (pipeData !== e_pd) begin
                    errors++;
                    $display("FAIL pipeData dut=%0d cyc=%0d got %h want %h", dut, cyc, pipeData, e_pd);
                end
            end
            if (prev_hold && e_pv) begin
                st_stall_holds++;
                checks++;
                if (pipeData !== prev_pd) begin
                    errors++;
                    $display("FAIL pipeData_hold dut=%0d cyc=%0d got %h want %h", dut, cyc, pipeData, prev_pd);
                end
            end
            if (e_done) begin
                checks++;
                if (jobResultCount !== BCW'(count)) begin
                    errors++;
                    $display("FAIL jobResultCount dut=%0d got %0d want %0d", dut, jobResultCount, count);
                end
            end
            if (botInReady === 1'b1) st_bir_high++;
            if (jobDone === 1'b1) st_done_pulses++;

            if (phase == 3) begin
                done = 1'b1;
            end else begin
                prev_hold = e_pv && !pipeReady && (phase == 1);
                prev_pd   = pipeData;
                if (phase == 2) begin
                    phase = 3;
                end else begin
                    if (e_pv && pipeReady) begin
                        if (phase == 0) begin
                            phase = (count == 0) ? 2 : 1;
                        end else begin
                            sent++;
                            if (st_xfer_n == 0) st_first = cyc;
                            st_last = cyc;
                            st_xfer_n++;
                            pend.push_back(cyc + $urandom_range(dly_min, dly_max));
                        end
                    end
                    if (resultValid) begin
                        pend.delete(due_idx);
                        recv++;
                        if (recv == count) phase = 2;
                    end
                    if ((sent - recv) > st_max_out) st_max_out = sent - recv;
                end
            end
        end
        resultValid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL job_timeout dut=%0d got sent=%0d recv=%0d want count=%0d", dut, sent, recv, count);
        end
        $display("job dut=%0d count=%0d xfers=%0d max_out=%0d cycles=%0d", dut, count, st_xfer_n, st_max_out, cyc_used);
    endtask

    task automatic test_reset();
        rst = 1'b1; jobValid = 1'b0; pipeReady = 1'b0; botInValid = 1'b0; resultValid = 1'b0; sel = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({jobReady, botInReady, pipeValid, pipeStartNewTop, jobDone, busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 000000", {jobReady, botInReady, pipeValid, pipeStartNewTop, jobDone, busy});
        end
        checks++;
        if (pipeData !== '0 || jobResultCount !== '0) begin
            errors++;
            $display("FAIL reset_data got %h/%0d want 0/0", pipeData, jobResultCount);
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (jobReady !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got ready=%b busy=%b want 1/0", jobReady, busy);
        end
    endtask

    task automatic test_basic();
        run_job(0, {16{8'hA5}}, 4, 0, 100, 3, 3);
        checks++;
        if (st_xfer_n != 4 || st_first != 1 || st_last != 4) begin
            errors++;
            $display("FAIL basic_bot_timing got n=%0d first=%0d last=%0d want 4/1/4", st_xfer_n, st_first, st_last);
        end
        checks++;
        if (st_done_pulses != 1) begin
            errors++;
            $display("FAIL basic_done_pulses got %0d want 1", st_done_pulses);
        end
    endtask

    task automatic test_zero_count();
        run_job(0, {$urandom(), $urandom(), $urandom(), $urandom()}, 0, 0, 100, 1, 1);
        checks++;
        if (st_bir_high != 0 || st_xfer_n != 0 || st_done_pulses != 1) begin
            errors++;
            $display("FAIL zero_count got bir=%0d xfers=%0d done=%0d want 0/0/1", st_bir_high, st_xfer_n, st_done_pulses);
        end
    endtask

    task automatic test_in_flight_limit();
        run_job(1, {$urandom(), $urandom(), $urandom(), $urandom()}, 5, 0, 100, 10, 10);
        checks++;
        if (st_max_out != MAX_B || st_xfer_n != 5) begin
            errors++;
            $display("FAIL in_flight_limit got max_out=%0d xfers=%0d want %0d/5", st_max_out, st_xfer_n, MAX_B);
        end
    endtask

    task automatic test_ready_toggle();
        run_job(0, {$urandom(), $urandom(), $urandom(), $urandom()}, 6, 1, 100, 2, 4);
        checks++;
        if (st_xfer_n != 6 || st_stall_holds == 0) begin
            errors++;
            $display("FAIL ready_toggle got xfers=%0d holds=%0d want 6/>0", st_xfer_n, st_stall_holds);
        end
    endtask

    task automatic test_back_to_back();
        // Result returns the cycle after each bot, so every later transfer
        // coincides with a result while one bot is in flight.
        run_job(1, {$urandom(), $urandom(), $urandom(), $urandom()}, 6, 0, 100, 1, 1);
        checks++;
        if (st_max_out != MAX_B - 1 || (st_last - st_first) != 5) begin
            errors++;
            $display("FAIL same_cycle got max_out=%0d span=%0d want %0d/5", st_max_out, st_last - st_first, MAX_B - 1);
        end
    endtask

    task automatic test_reset_mid_job();
        sel = 0;
        @(negedge clk);
        pipeReady = 1'b1; botInValid = 1'b1; resultValid = 1'b0;
        botIn = {$urandom(), $urandom(), $urandom(), $urandom()};
        jobValid = 1'b1; jobTop = {$urandom(), $urandom(), $urandom(), $urandom()}; jobBotCount = 2;
        @(negedge clk);
        jobValid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (pipeValid !== 1'b0 || botInReady !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL drain_state got pv=%b bir=%b busy=%b want 0/0/1", pipeValid, botInReady, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({jobReady, botInReady, pipeValid, pipeStartNewTop, jobDone, busy} !== 6'b0 ||
            pipeData !== '0 || jobResultCount !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs got %b data=%h cnt=%0d want all 0",
                     {jobReady, botInReady, pipeValid, pipeStartNewTop, jobDone, busy}, pipeData, jobResultCount);
        end
        rst = 1'b0;
        botInValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            resultValid = (i < 2);
            @(negedge clk);
            #1;
            checks++;
            if (jobReady !== 1'b1 || busy !== 1'b0 || jobDone !== 1'b0) begin
                errors++;
                $display("FAIL late_result_%0d got ready=%b busy=%b done=%b want 1/0/0", i, jobReady, busy, jobDone);
            end
        end
        resultValid = 1'b0;
        run_job(0, {$urandom(), $urandom(), $urandom(), $urandom()}, 1, 0, 100, 2, 2);
    endtask

    task automatic test_random();
        for (int j = 0; j < 12; j++) begin
            run_job($urandom_range(0, 1), {$urandom(), $urandom(), $urandom(), $urandom()},
                    $urandom_range(0, 9), 2, 70, 1, 6);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_count();
        test_in_flight_limit();
        test_ready_toggle();
        test_back_to_back();
        test_reset_mid_job();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
